// File: rtl/axi_r_distributor.sv
// axi_r_distributor: routes one AXI R channel to N_TARG_PORT ports by RID prefix.
// Ports: slave-side R in (rid_i carries dest), per-port R out, route_err_o pulse.
module axi_r_distributor #(
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_USER_W  = 6,
  parameter int AXI_ID_IN   = 4,
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
  parameter int AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [AXI_DATA_W-1:0]             rdata_i,
  input  logic [1:0]                        rresp_i,
  input  logic                              rlast_i,
  input  logic [AXI_USER_W-1:0]             ruser_i,
  input  logic [AXI_ID_OUT-1:0]             rid_i,
  input  logic                              rvalid_i,
  output logic                              rready_o,
  output logic [N_TARG_PORT*AXI_DATA_W-1:0] rdata_o,
  output logic [N_TARG_PORT*2-1:0]          rresp_o,
  output logic [N_TARG_PORT-1:0]            rlast_o,
  output logic [N_TARG_PORT*AXI_USER_W-1:0] ruser_o,
  output logic [N_TARG_PORT*AXI_ID_IN-1:0]  rid_o,
  output logic [N_TARG_PORT-1:0]            rvalid_o,
  input  logic [N_TARG_PORT-1:0]            rready_i,
  output logic                              route_err_o
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  localparam logic [LOG_N_TARG:0] PORTS =
    (LOG_N_TARG+1)'(N_TARG_PORT);

  state_t state;
  state_t state_nxt;

  logic live;
  logic err;
  logic wr_ptr;
  logic rd_ptr;

  logic [AXI_DATA_W-1:0] mem_data [2];
  logic [1:0]            mem_resp [2];
  logic                  mem_last [2];
  logic [AXI_USER_W-1:0] mem_user [2];
  logic [AXI_ID_IN-1:0]  mem_id   [2];
  logic [LOG_N_TARG-1:0] mem_dest [2];

  logic [LOG_N_TARG-1:0] dest_in;
  logic                  dest_bad;
  logic                  push;
  logic                  write;
  logic                  pop;
  logic                  head_valid;
  logic [LOG_N_TARG-1:0] head_dest;

  assign dest_in  = rid_i[AXI_ID_OUT-1:AXI_ID_IN];
  // Always false when the port count is a power of two.
  assign dest_bad = {1'b0, dest_in} >= PORTS;

  // live holds ready low until the first edge after reset release.
  assign rready_o = live & (state != FULL);
  assign push     = rvalid_i & rready_o;
  assign write    = push & ~dest_bad;

  assign head_valid = (state != EMPTY);
  assign head_dest  = mem_dest[rd_ptr];

  genvar k;
  generate
    for (k = 0; k < N_TARG_PORT; k++) begin : g_port
      assign rvalid_o[k] = head_valid &
        (head_dest == LOG_N_TARG'(k));
    end
  endgenerate

  assign rdata_o = {N_TARG_PORT{mem_data[rd_ptr]}};
  assign rresp_o = {N_TARG_PORT{mem_resp[rd_ptr]}};
  assign rlast_o = {N_TARG_PORT{mem_last[rd_ptr]}};
  assign ruser_o = {N_TARG_PORT{mem_user[rd_ptr]}};
  assign rid_o   = {N_TARG_PORT{mem_id[rd_ptr]}};

  // Only the selected port can have its valid set.
  assign pop = |(rvalid_o & rready_i);

  assign route_err_o = err;

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (write) state_nxt = ONE;
      end
      ONE: begin
        if (write && !pop) state_nxt = FULL;
        else if (!write && pop) state_nxt = EMPTY;
      end
      FULL: begin
        if (pop) state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      live   <= 1'b0;
      err    <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      err   <= push & dest_bad;
      if (write) wr_ptr <= ~wr_ptr;
      if (pop)   rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (write) begin
      mem_data[wr_ptr] <= rdata_i;
      mem_resp[wr_ptr] <= rresp_i;
      mem_last[wr_ptr] <= rlast_i;
      mem_user[wr_ptr] <= ruser_i;
      mem_id[wr_ptr]   <= rid_i[AXI_ID_IN-1:0];
      mem_dest[wr_ptr] <= dest_in;
    end
  end

endmodule
